gelu_lut_loader: RTL and testbench

GELU_LUT_LOADER -- requirements
Module: gelu_lut_loader

---
 rtl/gelu_lut_loader_pkg.sv | 21 ++
 rtl/gelu_lut_loader.sv | 170 +++++++++++++++++
 tb/tb_gelu_lut_loader.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gelu_lut_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gelu_lut_loader_pkg
// Description : Shared types and default widths for the GELU LUT loader.
// Revision    : 1.0 - initial release
// ============================================================================
package gelu_lut_loader_pkg;

    // Default LUT geometry: 256 entries of 8 bits.
    localparam int c_lut_addr_default = 8;
    localparam int c_lut_data_default = 8;

    // Loader control states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : gelu_lut_loader_pkg
`default_nettype wire

// File: rtl/gelu_lut_loader.sv
`default_nettype none
// ============================================================================
// Module      : gelu_lut_loader
// Description : Streams a run of entries into the GELU lookup table write
//               port. A start request latches a base address and entry count;
//               each accepted stream beat is written one cycle later at an
//               auto-incrementing (wrapping) address. A single done pulse
//               marks the final write. Loads may be aborted.
//               Optional macro GELU_LUT_LOADER_CHECKSUM_EN adds a cfg_checksum
//               input and flags a sticky err when the modulo sum of the loaded
//               entries does not match it.
// Revision    : 1.0 - initial release
// ============================================================================
module gelu_lut_loader
    import gelu_lut_loader_pkg::*;
#(
    parameter int LUT_ADDR = c_lut_addr_default,
    parameter int LUT_DATA = c_lut_data_default
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_start,
    input  logic [LUT_ADDR-1:0] cfg_base,
    input  logic [LUT_ADDR-1:0] cfg_len,
    input  logic                cfg_abort,
`ifdef GELU_LUT_LOADER_CHECKSUM_EN
    input  logic [LUT_DATA-1:0] cfg_checksum,
`endif
    input  logic                s_valid,
    input  logic [LUT_DATA-1:0] s_data,
    output logic                s_ready,
    output logic                lut_wen,
    output logic [LUT_ADDR-1:0] lut_waddr,
    output logic [LUT_DATA-1:0] lut_wdata,
    output logic                busy,
    output logic                done,
    output logic                err
);

    state_t                r_state;
    state_t                w_state_next;
    logic                  w_start;
    logic                  w_accept;
    logic                  w_last_beat;

    logic [LUT_ADDR-1:0]   r_addr;
    logic [LUT_ADDR-1:0]   r_remain;

    logic                  r_wen;
    logic [LUT_ADDR-1:0]   r_waddr;
    logic [LUT_DATA-1:0]   r_wdata;

    // A beat is taken whenever the loader is in LOAD and the source offers data.
    assign w_accept    = s_valid && (r_state == LOAD);
    // Remaining count of 1 marks the final beat; a length of 0 wraps through
    // all ones and so yields the full 2^LUT_ADDR beats.
    assign w_last_beat = (r_remain == LUT_ADDR'(1));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and state-decoded outputs; abort takes priority over finishing.
    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        s_ready      = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            IDLE: begin
                if (cfg_start) begin
                    w_start      = 1'b1;
                    w_state_next = LOAD;
                end
            end
            LOAD: begin
                s_ready = 1'b1;
                busy    = 1'b1;
                if (cfg_abort) begin
                    w_state_next = IDLE;
                end else if (w_accept && w_last_beat) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                busy         = 1'b1;
                done         = 1'b1;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Address and remaining-entry counters, loaded on start, stepped per beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr   <= '0;
            r_remain <= '0;
        end else if (w_start) begin
            r_addr   <= cfg_base;
            r_remain <= cfg_len;
        end else if (w_accept) begin
            r_addr   <= r_addr + LUT_ADDR'(1);
            r_remain <= r_remain - LUT_ADDR'(1);
        end
    end

    // Write-port register: one-cycle latency, address/data hold between writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wen   <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else begin
            r_wen <= w_accept;
            if (w_accept) begin
                r_waddr <= r_addr;
                r_wdata <= s_data;
            end
        end
    end

    assign lut_wen   = r_wen;
    assign lut_waddr = r_waddr;
    assign lut_wdata = r_wdata;

`ifdef GELU_LUT_LOADER_CHECKSUM_EN
    logic [LUT_DATA-1:0] r_sum;
    logic [LUT_DATA-1:0] r_chk;
    logic                r_err;
    logic                w_err_now;

    // In DONE the sum already includes the final beat accepted last cycle.
    assign w_err_now = (r_state == DONE) && (r_sum != r_chk);

    // Running sum of accepted entries and sticky mismatch flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum <= '0;
            r_chk <= '0;
            r_err <= 1'b0;
        end else if (w_start) begin
            r_sum <= '0;
            r_chk <= cfg_checksum;
            r_err <= 1'b0;
        end else begin
            if (w_accept) begin
                r_sum <= r_sum + s_data;
            end
            if (w_err_now) begin
                r_err <= 1'b1;
            end
        end
    end

    assign err = r_err | w_err_now;
`else
    assign err = 1'b0;
`endif

endmodule : gelu_lut_loader
`default_nettype wire

// File: tb/tb_gelu_lut_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_gelu_lut_loader
// Description : Self-checking bench for gelu_lut_loader. A table of directed
//               loads plus randomized loads are compared against a list-based
//               reference (expected write i lands at base+i with entry i).
//               Build with GELU_LUT_LOADER_CHECKSUM_EN to cover the checksum.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gelu_lut_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_start;
    logic [7:0] cfg_base;
    logic [7:0] cfg_len;
    logic       cfg_abort;
`ifdef GELU_LUT_LOADER_CHECKSUM_EN
    logic [7:0] cfg_checksum;
`endif
    logic       s_valid;
    logic [7:0] s_data;
    logic       s_ready;
    logic       lut_wen;
    logic [7:0] lut_waddr;
    logic [7:0] lut_wdata;
    logic       busy;
    logic       done;
    logic       err;

    int n_tests = 0;
    int n_fail  = 0;

    // Write monitor results
    logic [15:0] act_q[$];
    int          done_cnt;
    int          done_nowen;
    logic [7:0]  done_addr;
    logic        done_err;

    gelu_lut_loader #(.LUT_ADDR(8), .LUT_DATA(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_start (cfg_start),
        .cfg_base  (cfg_base),
        .cfg_len   (cfg_len),
        .cfg_abort (cfg_abort),
`ifdef GELU_LUT_LOADER_CHECKSUM_EN
        .cfg_checksum (cfg_checksum),
`endif
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_ready   (s_ready),
        .lut_wen   (lut_wen),
        .lut_waddr (lut_waddr),
        .lut_wdata (lut_wdata),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Global time limit
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Capture every write and done pulse, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (lut_wen) act_q.push_back({lut_waddr, lut_wdata});
            if (done) begin
                done_cnt++;
                if (!lut_wen) done_nowen++;
                done_addr = lut_waddr;
                done_err  = err;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        act_q.delete();
        done_cnt   = 0;
        done_nowen = 0;
        done_addr  = 8'h00;
        done_err   = 1'b0;
    endtask

    // One load transaction; the reference is the list of entries actually
    // handed over, each expected at base + index (mod 256).
    task automatic run_load(input logic [7:0] base, input int n, input int pat,
                            input int gap, input int ab_at, input int ab_mode,
                            input int chk_bad, output int nw,
                            output logic [7:0] last, output int ndone);
        logic [7:0] dat[256];
        logic [7:0] sum;
        int         sent;
        int         guard;
        bit         aborted;
        int         exp_done;
        int         exp_err;
        sum = 8'h00;
        for (int i = 0; i < n; i++) begin
            if (pat == 1)      dat[i] = 8'((i + 1) * 17);
            else if (pat == 2) dat[i] = 8'h80;
            else               dat[i] = 8'($urandom);
            sum = sum + dat[i];
        end
        clear_mon();
        @(posedge clk); #1;
        cfg_start = 1'b1;
        cfg_base  = base;
        cfg_len   = 8'(n);
`ifdef GELU_LUT_LOADER_CHECKSUM_EN
        cfg_checksum = sum + 8'(chk_bad);
`endif
        @(posedge clk); #1;
        cfg_start = 1'b0;
        cfg_base  = 8'($urandom);
        cfg_len   = 8'($urandom);
`ifdef GELU_LUT_LOADER_CHECKSUM_EN
        cfg_checksum = 8'($urandom);
`endif
        sent = 0; guard = 0; aborted = 1'b0;
        while (sent < n && !aborted && guard < 5000) begin
            guard++;
            chk("s_ready_in_load", int'(s_ready), 1);
            cfg_start = ($urandom_range(0, 9) == 0);
            if (ab_mode != 0 && sent == ab_at) begin
                cfg_abort = 1'b1;
                s_valid   = (ab_mode == 2);
                s_data    = dat[sent];
                if (ab_mode == 2) sent++;
                aborted = 1'b1;
            end else if ($urandom_range(0, 99) < gap) begin
                s_valid = 1'b0;
                s_data  = 8'($urandom);
            end else begin
                s_valid = 1'b1;
                s_data  = dat[sent];
                sent++;
            end
            @(posedge clk); #1;
        end
        chk("load_cycle_budget", int'(guard < 5000), 1);
        s_valid   = 1'b0;
        cfg_start = 1'b0;
        // An abort landing in DONE must be ignored.
        cfg_abort = !aborted && ($urandom_range(0, 1) == 1);
        @(posedge clk); #1;
        cfg_abort = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        exp_done = aborted ? 0 : 1;
        chk("write_count", act_q.size(), sent);
        for (int i = 0; i < sent && i < act_q.size(); i++) begin
            chk("write_addr", int'(act_q[i][15:8]), int'(8'(base + 8'(i))));
            chk("write_data", int'(act_q[i][7:0]), int'(dat[i]));
        end
        chk("done_count", done_cnt, exp_done);
        chk("done_without_wen", done_nowen, 0);
        if (exp_done == 1)
            chk("done_addr", int'(done_addr), int'(8'(base + 8'(n - 1))));
        chk("busy_idle", int'(busy), 0);
`ifdef GELU_LUT_LOADER_CHECKSUM_EN
        exp_err = (!aborted && chk_bad != 0) ? 1 : 0;
        if (exp_done == 1) chk("err_at_done", int'(done_err), exp_err);
`else
        exp_err = 0;
`endif
        chk("err_after", int'(err), exp_err);
        nw    = act_q.size();
        last  = (act_q.size() > 0) ? act_q[act_q.size() - 1][15:8] : 8'h00;
        ndone = done_cnt;
    endtask

    typedef struct {
        logic [7:0] base;
        int         len;
        int         pat;
        int         gap;
        int         ab_at;
        int         ab_mode;
        int         chk_bad;
        int         exp_w;
        logic [7:0] exp_last;
        int         exp_done;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int         nw;
        int         nd;
        logic [7:0] last;

        vecs[0] = '{8'h00,   4, 1,  0, 0, 0, 0,   4, 8'h03, 1};
        vecs[1] = '{8'hFE,   3, 0, 60, 0, 0, 0,   3, 8'h00, 1};
        vecs[2] = '{8'hF0,  32, 0, 20, 0, 0, 0,  32, 8'h0F, 1};
        vecs[3] = '{8'h37, 256, 0, 10, 0, 0, 0, 256, 8'h36, 1};
        vecs[4] = '{8'h10,   5, 0,  0, 2, 1, 0,   2, 8'h11, 0};
        vecs[5] = '{8'h40,   5, 0, 30, 2, 2, 0,   3, 8'h42, 0};
        vecs[6] = '{8'h20,   1, 0,  0, 0, 0, 0,   1, 8'h20, 1};
        vecs[7] = '{8'h00,   2, 2,  0, 0, 0, 0,   2, 8'h01, 1};
        vecs[8] = '{8'h00,   2, 2,  0, 0, 0, 1,   2, 8'h01, 1};

        rst = 1'b1; cfg_start = 1'b0; cfg_base = 8'h00; cfg_len = 8'h00;
        cfg_abort = 1'b0; s_valid = 1'b0; s_data = 8'h00;
`ifdef GELU_LUT_LOADER_CHECKSUM_EN
        cfg_checksum = 8'h00;
`endif
        clear_mon();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_s_ready", int'(s_ready), 0);
        chk("rst_lut_wen", int'(lut_wen), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_waddr", int'(lut_waddr), 0);
        chk("rst_wdata", int'(lut_wdata), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Abort while idle is ignored.
        cfg_abort = 1'b1;
        @(posedge clk); #1;
        cfg_abort = 1'b0;
        @(negedge clk);
        chk("idle_abort_busy", int'(busy), 0);
        chk("idle_abort_ready", int'(s_ready), 0);

        // Directed table
        for (int v = 0; v < 9; v++) begin
            run_load(vecs[v].base, vecs[v].len, vecs[v].pat, vecs[v].gap,
                     vecs[v].ab_at, vecs[v].ab_mode, vecs[v].chk_bad,
                     nw, last, nd);
            chk("tbl_writes", nw, vecs[v].exp_w);
            chk("tbl_last_addr", int'(last), int'(vecs[v].exp_last));
            chk("tbl_done", nd, vecs[v].exp_done);
        end

        // Reset in the middle of a load: no further writes, no done.
        clear_mon();
        @(posedge clk); #1;
        cfg_start = 1'b1; cfg_base = 8'h50; cfg_len = 8'd8;
        @(posedge clk); #1;
        cfg_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s_valid = 1'b1; s_data = 8'(8'hA0 + 8'(i));
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1; s_valid = 1'b1; s_data = 8'hEE;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_lut_wen", int'(lut_wen), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_s_ready", int'(s_ready), 0);
        chk("midrst_waddr", int'(lut_waddr), 0);
        @(posedge clk); #1;
        rst = 1'b0; s_valid = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        s_valid = 1'b0;
        chk("midrst_writes", act_q.size(), 3);
        if (act_q.size() == 3)
            chk("midrst_last_addr", int'(act_q[2][15:8]), 8'h52);
        chk("midrst_done", done_cnt, 0);
        chk("midrst_idle_ready", int'(s_ready), 0);
        run_load(8'h90, 2, 0, 0, 0, 0, 0, nw, last, nd);
        chk("post_rst_writes", nw, 2);
        chk("post_rst_last", int'(last), 8'h91);

        // Randomized loads against the reference
        for (int r = 0; r < 15; r++) begin
            int n;
            int mode;
            n    = int'($urandom_range(1, 40));
            mode = int'($urandom_range(0, 3));
            if (mode == 3) mode = 0;
            run_load(8'($urandom), n, 0, int'($urandom_range(0, 50)),
                     int'($urandom_range(1, n)), mode,
                     int'($urandom_range(0, 1)), nw, last, nd);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_gelu_lut_loader
`default_nettype wire
